// File: rtl/common_pkg.sv
// Shared execute-stage types: divider opcodes, divider FSM states and latency.
package common_pkg;

    typedef enum logic [1:0] {
        DIV_SIGNED   = 2'd0,
        DIV_UNSIGNED = 2'd1,
        REM_SIGNED   = 2'd2,
        REM_UNSIGNED = 2'd3
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int DIV_LATENCY = 34;

    function automatic logic is_signed_op(input div_op_t op);
        return (op == DIV_SIGNED) || (op == REM_SIGNED);
    endfunction

    function automatic logic is_rem_op(input div_op_t op);
        return (op == REM_SIGNED) || (op == REM_UNSIGNED);
    endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional DIV_EARLY_OUT_EN: divide-by-zero, signed overflow and divide-by-one finish in one cycle.
module div_unit
    import common_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [XLEN-1:0] left_operand,
    input  logic [XLEN-1:0] right_operand,
    input  div_op_t         div_op,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] div_res
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t       state_q;
    div_op_t          op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  dvd_q, dvs_q, rem_q, quo_q, div_res_q;
    logic             q_neg_q, r_neg_q, busy_q, done_q;

    logic             lhs_neg_d, rhs_neg_d, step_bit_d, early_d;
    logic [XLEN-1:0]  dvd_mag_d, dvs_mag_d, step_rem_d, quo_fix_d, rem_fix_d;
    logic [XLEN-1:0]  res_d, early_res_d;

    // Trial value is XLEN+1 bits so a remainder with its MSB set is never truncated before compare.
    function automatic logic [XLEN:0] div_step(input logic [XLEN-1:0] rem,
                                               input logic            msb,
                                               input logic [XLEN-1:0] dvs);
        logic [XLEN:0] trial;
        trial = {rem, msb};
        if (trial >= {1'b0, dvs})
            return {1'b1, trial[XLEN-1:0] - dvs};
        else
            return {1'b0, trial[XLEN-1:0]};
    endfunction

    always_comb begin
        lhs_neg_d = left_operand[XLEN-1]  & is_signed_op(div_op);
        rhs_neg_d = right_operand[XLEN-1] & is_signed_op(div_op);
        dvd_mag_d = lhs_neg_d ? -left_operand  : left_operand;
        dvs_mag_d = rhs_neg_d ? -right_operand : right_operand;

        {step_bit_d, step_rem_d} = div_step(rem_q, dvd_q[XLEN-1], dvs_q);

        quo_fix_d = q_neg_q ? -quo_q : quo_q;
        if (dvs_q == '0)
            quo_fix_d = '1;
        rem_fix_d = r_neg_q ? -rem_q : rem_q;
        res_d     = is_rem_op(op_q) ? rem_fix_d : quo_fix_d;

        early_d     = 1'b0;
        early_res_d = '0;
`ifdef DIV_EARLY_OUT_EN
        if (right_operand == '0) begin
            early_d     = 1'b1;
            early_res_d = is_rem_op(div_op) ? left_operand : '1;
        end else if (is_signed_op(div_op) && left_operand == INT_MIN && right_operand == '1) begin
            early_d     = 1'b1;
            early_res_d = is_rem_op(div_op) ? '0 : INT_MIN;
        end else if (right_operand == XLEN'(1)) begin
            early_d     = 1'b1;
            early_res_d = is_rem_op(div_op) ? '0 : left_operand;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= DIV_SIGNED;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_res_q <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q    <= div_op;
                        dvd_q   <= dvd_mag_d;
                        dvs_q   <= dvs_mag_d;
                        q_neg_q <= lhs_neg_d ^ rhs_neg_d;
                        r_neg_q <= lhs_neg_d;
                        rem_q   <= '0;
                        quo_q   <= '0;
                        cnt_q   <= CNT_W'(XLEN-1);
                        busy_q  <= 1'b1;
                        if (early_d) begin
                            div_res_q <= early_res_d;
                            done_q    <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= step_rem_d;
                    quo_q <= {quo_q[XLEN-2:0], step_bit_d};
                    dvd_q <= {dvd_q[XLEN-2:0], 1'b0};
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0)
                        state_q <= FIX;
                end
                FIX: begin
                    div_res_q <= res_d;
                    done_q    <= 1'b1;
                    state_q   <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign div_res = div_res_q;

endmodule
